firebird7_in_gate1_tessent_data_tdr_w3: RTL and testbench
=========================================================

# firebird7_in_gate1_tessent_data_tdr_w3

IJTAG test data register that produces the `ijtag_select` and `ijtag_data_in` controls consumed by the gate1 3-bit data mux. It captures the functional value on the mux output back into its scan chain, so the same data flows in both directions. The block sits on the gate1 IJTAG network between the SIB and the data mux. Updates are committed only after a shift of exactly the chain length.

## Interface
- `WIDTH`, 3: data bits controlled and observed.
- `ijtag_tck` in 1: the only clock; all state changes on its rising edge.
- `ijtag_reset` in 1: reset, synchronous, active-high.
- `ijtag_sel` in 1: network select; when low, ce/se/ue are ignored.
- `ijtag_ce` in 1: capture enable.
- `ijtag_se` in 1: shift enable.
- `ijtag_ue` in 1: update enable.
- `ijtag_si` in 1: scan in.
- `ijtag_so` out 1: scan out, equal to `shift_reg[0]`.
- `functional_data_in` in WIDTH: observed mux output, loaded on capture.
- `ijtag_select` out 1: update-register select bit, driven to the mux.
- `ijtag_data_out` out WIDTH: update-register data, driven to the mux `ijtag_data_in`.
- `update_err` out 1: sticky flag, set when an update is rejected.

## Operation
- Chain length L = WIDTH+2, or WIDTH+3 with parity.
  - Bits [WIDTH-1:0] are data.
  - Bit WIDTH is select.
  - Bit WIDTH+1 is the error status bit.
  - Bit WIDTH+2 is parity, present only with parity enabled.
- Shift: `shift_reg <= {ijtag_si, shift_reg[L-1:1]}`, so LSB exits first.
- Operation priority when `ijtag_sel`=1: capture, then shift, then update. Lower-priority enables asserted in the same cycle are ignored.
- Capture loads the chain as follows:
  - data ← `functional_data_in`
  - select ← current `ijtag_select`
  - status ← `update_err`
  - parity ← XOR of the captured data and select bits
- Capture clears `shift_cnt`.
- `shift_cnt` has width $clog2(L+1)+1. It increments on each shift and saturates at all-ones.
- An update is accepted iff `shift_cnt == L`, plus a parity match when parity is enabled.
  - Accepted: `ijtag_data_out` ← data bits, `ijtag_select` ← select bit, `shift_cnt` ← 0.
  - Rejected: outputs hold, `update_err` ← 1, `shift_cnt` ← 0.
- `update_err` clears only on reset, or on an accepted update whose status bit (WIDTH+1) shifts in as 0. Writing 1 to the status bit keeps the flag set.
- The status bit is ignored for rejected updates.
- Reset mid-shift discards the partial shift: chain, counter and outputs all return to reset values.

## Timing
- Reset values (one edge with `ijtag_reset`=1):
  - `shift_reg` = 0
  - `shift_cnt` = 0
  - `ijtag_select` = 0 (functional path selected)
  - `ijtag_data_out` = 0
  - `update_err` = 0
- Reset overrides all enables in the same cycle.
- Capture: chain holds `functional_data_in` sampled at edge N; `ijtag_so` shows bit 0 after edge N.
- Shift: one bit per edge. The first shifted-in `ijtag_si` bit reaches bit 0 after L shifts.
- Update: `ijtag_select` and `ijtag_data_out` change after the update edge. Latency is 1 cycle from `ijtag_ue`.
- Outputs are glitch-free registers, with no combinational path from inputs to `ijtag_select` or `ijtag_data_out`.
- `ijtag_so` is combinational from the register only.

## Configuration
- `FIREBIRD7_TDR_PARITY_EN` defined:
  - L = WIDTH+3, and a parity bit sits at the MSB of the chain.
  - An update is accepted only if the shifted parity bit equals XOR of the data and select bits; a mismatch counts as rejected.
- Undefined: L = WIDTH+2, there is no parity bit, and only the length check applies.

## Structure
- Shared package `firebird7_in_gate1_tdr_pkg` holds:
  - Chain bit-index constants: `DATA_LSB`, `SEL_BIT`, `STAT_BIT`, `PAR_BIT`.
  - A localparam function computing L from WIDTH and the macro.
  - The `shift_cnt` width.
- One sub-module, `firebird7_in_gate1_tdr_shift_counter`: saturating counter with clear and increment.
- Everything else lives in a single always_ff block.

## Test plan
- Reset, then idle 5 cycles → `ijtag_select`=0, `ijtag_data_out`=3'b000, `update_err`=0, `ijtag_so`=0.
- Capture with `functional_data_in`=3'b101, then shift L bits → `ijtag_so` emits 1,0,1,0,0 (plus parity 0 if enabled).
- Shift exactly L bits encoding data=3'b110, select=1, status=0 (plus correct parity), then update → `ijtag_data_out`=3'b110, `ijtag_select`=1, `update_err`=0.
- Shift L-1 bits, then update → outputs unchanged and `update_err`=1. A later correct L-bit shift with status=0 and update clears the flag.
- With the parity macro: correct length but wrong parity → update rejected and `update_err`=1. Without the macro, the same stimulus updates the outputs.
- `ijtag_ce`+`ijtag_se`+`ijtag_ue` asserted together → capture only. `ijtag_sel`=0 with `ijtag_se`=1 → chain unchanged. Reset asserted mid-shift → all reset values on the next edge.

Source files
------------

// File: rtl/firebird7_in_gate1_tdr_pkg.sv
// Shared constants for the gate1 data TDR: chain bit layout, chain length and counter width.
// Chain length depends on FIREBIRD7_TDR_PARITY_EN (adds a parity bit at the MSB).
package firebird7_in_gate1_tdr_pkg;

    localparam int unsigned TDR_WIDTH = 3;

    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned SEL_BIT  = TDR_WIDTH;
    localparam int unsigned STAT_BIT = TDR_WIDTH + 1;
    localparam int unsigned PAR_BIT  = TDR_WIDTH + 2;

    function automatic int unsigned chain_len(input int unsigned width);
`ifdef FIREBIRD7_TDR_PARITY_EN
        return width + 3;
`else
        return width + 2;
`endif
    endfunction

    localparam int unsigned CHAIN_LEN = chain_len(TDR_WIDTH);
    localparam int unsigned CNT_W     = $clog2(CHAIN_LEN + 1) + 1;

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_tdr_w3_shift_counter.sv
// Saturating shift counter for the gate1 data TDR; clear wins over increment.
module firebird7_in_gate1_tdr_shift_counter #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_tdr_w3.sv
// IJTAG data TDR driving the gate1 3-bit data mux select/data and capturing its output.
// Optional parity bit and parity-checked updates enabled by FIREBIRD7_TDR_PARITY_EN.
module firebird7_in_gate1_tessent_data_tdr_w3
    import firebird7_in_gate1_tdr_pkg::*;
#(
    parameter int unsigned WIDTH = TDR_WIDTH
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] functional_data_in,
    output logic             ijtag_select,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             update_err
);

    localparam int unsigned L = chain_len(WIDTH);

    logic [L-1:0]     shift_reg;
    logic [L-1:0]     cap_vec;
    logic [CNT_W-1:0] shift_cnt;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             len_ok;
    logic             par_ok;

    always_comb begin
        cap_vec                      = '0;
        cap_vec[DATA_LSB +: WIDTH]   = functional_data_in;
        cap_vec[SEL_BIT]             = ijtag_select;
        cap_vec[STAT_BIT]            = update_err;
`ifdef FIREBIRD7_TDR_PARITY_EN
        cap_vec[PAR_BIT]             = ^{ijtag_select, functional_data_in};
`endif
    end

    // Counter clears on capture and on any update attempt; only a pure shift increments.
    assign cnt_clr = ijtag_sel & (ijtag_ce | (~ijtag_se & ijtag_ue));
    assign cnt_inc = ijtag_sel & ~ijtag_ce & ijtag_se;

    firebird7_in_gate1_tdr_shift_counter #(
        .W (CNT_W)
    ) u_shift_counter (
        .clk (ijtag_tck),
        .rst (ijtag_reset),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .cnt (shift_cnt)
    );

    assign len_ok = (shift_cnt == CNT_W'(L));
`ifdef FIREBIRD7_TDR_PARITY_EN
    assign par_ok = (shift_reg[PAR_BIT] == ^shift_reg[SEL_BIT:DATA_LSB]);
`else
    assign par_ok = 1'b1;
`endif

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            shift_reg      <= '0;
            ijtag_select   <= 1'b0;
            ijtag_data_out <= '0;
            update_err     <= 1'b0;
        end else if (ijtag_sel) begin
            if (ijtag_ce) begin
                shift_reg <= cap_vec;
            end else if (ijtag_se) begin
                shift_reg <= {ijtag_si, shift_reg[L-1:1]};
            end else if (ijtag_ue) begin
                if (len_ok && par_ok) begin
                    ijtag_data_out <= shift_reg[DATA_LSB +: WIDTH];
                    ijtag_select   <= shift_reg[SEL_BIT];
                    if (!shift_reg[STAT_BIT]) begin
                        update_err <= 1'b0;
                    end
                end else begin
                    update_err <= 1'b1;
                end
            end
        end
    end

    assign ijtag_so = shift_reg[0];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_tdr_w3.sv
// Directed scoreboard bench for the gate1 data TDR (default and FIREBIRD7_TDR_PARITY_EN builds).
module tb_firebird7_in_gate1_tessent_data_tdr_w3;

`ifdef FIREBIRD7_TDR_PARITY_EN
    localparam int L = 6;
    localparam bit PAR = 1'b1;
`else
    localparam int L = 5;
    localparam bit PAR = 1'b0;
`endif
    localparam int CW     = $clog2(L + 1) + 1;
    localparam int CNTMAX = (1 << CW) - 1;

    logic       clk = 1'b0;
    logic       rst, sel, ce, se, ue, si;
    logic       so;
    logic [2:0] fdi;
    logic       select_o;
    logic [2:0] data_o;
    logic       err_o;

    firebird7_in_gate1_tessent_data_tdr_w3 #(.WIDTH(3)) dut (
        .ijtag_tck          (clk),
        .ijtag_reset        (rst),
        .ijtag_sel          (sel),
        .ijtag_ce           (ce),
        .ijtag_se           (se),
        .ijtag_ue           (ue),
        .ijtag_si           (si),
        .ijtag_so           (so),
        .functional_data_in (fdi),
        .ijtag_select       (select_o),
        .ijtag_data_out     (data_o),
        .update_err         (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         kind;
        logic [7:0] val;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  passes = 0;

    // bench reference model
    logic [7:0] m_chain;
    int         m_cnt;
    logic       m_sel;
    logic [2:0] m_data;
    logic       m_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input int kind, input logic [7:0] v);
        sb_t e;
        e.tag = tag; e.kind = kind; e.val = v;
        sb.push_back(e);
    endtask

    task automatic expect_outputs(input string tag);
        push({tag, "_sel"},  0, {7'd0, m_sel});
        push({tag, "_data"}, 1, {5'd0, m_data});
        push({tag, "_err"},  2, {7'd0, m_err});
        push({tag, "_so"},   3, {7'd0, m_chain[0]});
    endtask

    task automatic drain();
        sb_t        e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       obs = {7'd0, select_o};
                1:       obs = {5'd0, data_o};
                2:       obs = {7'd0, err_o};
                default: obs = {7'd0, so};
            endcase
            checks++;
            assert (obs === e.val) passes++;
            else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    function automatic logic [7:0] mk_vec(input logic [2:0] d, input logic s,
                                         input logic st, input logic badpar);
        logic [7:0] v;
        v      = '0;
        v[2:0] = d;
        v[3]   = s;
        v[4]   = st;
        v[5]   = (^{s, d}) ^ badpar;
        return v;
    endfunction

    task automatic do_capture(input logic [2:0] d);
        fdi = d; ce = 1'b1;
        m_chain      = '0;
        m_chain[2:0] = d;
        m_chain[3]   = m_sel;
        m_chain[4]   = m_err;
        if (PAR) m_chain[5] = ^{m_sel, d};
        m_cnt = 0;
        tick();
        ce = 1'b0;
    endtask

    task automatic shift_vec(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            si = v[i]; se = 1'b1;
            m_chain = {si, m_chain[7:1]};
            m_chain[L] = 1'b0;
            m_chain[L-1] = si;
            if (m_cnt < CNTMAX) m_cnt++;
            tick();
        end
        se = 1'b0; si = 1'b0;
    endtask

    task automatic do_update(input string tag);
        logic ok;
        ok = (m_cnt == L);
        if (PAR && (m_chain[5] != ^m_chain[3:0])) ok = 1'b0;
        if (ok) begin
            m_data = m_chain[2:0];
            m_sel  = m_chain[3];
            if (!m_chain[4]) m_err = 1'b0;
        end else begin
            m_err = 1'b1;
        end
        m_cnt = 0;
        ue = 1'b1;
        expect_outputs(tag);
        tick();
        ue = 1'b0;
        drain();
    endtask

    task automatic model_reset();
        m_chain = '0; m_cnt = 0; m_sel = 1'b0; m_data = '0; m_err = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0; fdi = '0;
        model_reset();
        tick();
        rst = 1'b0;
        repeat (5) tick();
        expect_outputs("reset");
        drain();

        // capture 101 and observe the chain shifting out LSB first
        sel = 1'b1;
        do_capture(3'b101);
        for (int k = 0; k < L; k++) begin
            push($sformatf("cap_so%0d", k), 3, {7'd0, m_chain[0]});
            drain();
            shift_vec(8'h00, 1);
        end
        do_update("upd_zero");

        shift_vec(mk_vec(3'b110, 1'b1, 1'b0, 1'b0), L);
        do_update("upd_110");

        shift_vec(mk_vec(3'b011, 1'b0, 1'b0, 1'b0), L - 1);
        do_update("short");

        shift_vec(mk_vec(3'b010, 1'b1, 1'b0, 1'b0), L);
        do_update("clear_err");

        // wrong parity: rejected with parity, accepted without
        shift_vec(mk_vec(3'b001, 1'b0, 1'b0, 1'b1), L);
        do_update("badpar");
        shift_vec(mk_vec(3'b010, 1'b1, 1'b0, 1'b0), L);
        do_update("recover");

        // status written as 1 keeps a set flag
        shift_vec(mk_vec(3'b111, 1'b0, 1'b0, 1'b0), 2);
        do_update("short2");
        shift_vec(mk_vec(3'b100, 1'b1, 1'b1, 1'b0), L);
        do_update("stat1");
        shift_vec(mk_vec(3'b100, 1'b1, 1'b0, 1'b0), L);
        do_update("stat0");

        // overlong shift saturates the counter and is rejected
        shift_vec(8'hA5, 20);
        do_update("overlong");

        // all enables together: capture only
        fdi = 3'b111; ce = 1'b1; se = 1'b1; ue = 1'b1; si = 1'b0;
        m_chain      = '0;
        m_chain[2:0] = 3'b111;
        m_chain[3]   = m_sel;
        m_chain[4]   = m_err;
        if (PAR) m_chain[5] = ^{m_sel, 3'b111};
        m_cnt = 0;
        expect_outputs("all_en");
        tick();
        ce = 1'b0; se = 1'b0; ue = 1'b0;
        drain();

        // deselected shift leaves the chain alone
        sel = 1'b0; se = 1'b1; si = 1'b0;
        expect_outputs("desel");
        tick();
        se = 1'b0; sel = 1'b1;
        drain();
        for (int k = 1; k < 4; k++) begin
            shift_vec(8'h00, 1);
            push($sformatf("after_desel_so%0d", k), 3, {7'd0, m_chain[0]});
            drain();
        end

        // reset mid-shift
        shift_vec(8'hFF, 2);
        rst = 1'b1; se = 1'b1; si = 1'b1;
        model_reset();
        expect_outputs("mid_rst");
        tick();
        rst = 1'b0; se = 1'b0; si = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
